vga_scan_timer: RTL
===================

Name: vga_scan_timer

Overview:
- Free-running XGA-style raster timing generator for the TinyQV VGA peripheral; sits directly upstream of the pixel/VRAM-index stage.
- Produces the beam position (x, y) and the hsync, vsync and blank strobes.
- Produces a one-cycle retrace pulse that advances the pixel stage to the next scanline.
- Raises a sticky interrupt on hblank/vblank; the CPU clears it.
- Default timing: 1024x768@60 running off the 64 MHz project clock.

Parameters:
H_VISIBLE, 1024, active clocks per line
H_FRONT, 24, front porch clocks
H_SYNC, 136, hsync width clocks
H_BACK, 160, back porch clocks (H_TOTAL = 1344)
V_VISIBLE, 768, active lines
V_FRONT, 3, front porch lines
V_SYNC, 6, vsync width lines
V_BACK, 29, back porch lines (V_TOTAL = 806)
NARROW_VISIBLE, 960, active clocks when narrow_960 = 1
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cli  in  1  clear interrupt flag (level, sampled each clk)
enable_interrupt_on_hblank  in  1  arm hblank interrupt source
enable_interrupt_on_vblank  in  1  arm vblank interrupt source
narrow_960  in  1  blank x >= NARROW_VISIBLE
x  out  11  horizontal counter, 0..H_TOTAL-1
y  out  10  vertical counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
retrace  out  1  one-cycle pulse, last clock of every line
blank  out  1  1 outside the active area
interrupt  out  1  sticky interrupt request

Behaviour:
- Reset values: x=0, y=0, blank=0, hsync=vsync=inactive (1 when SYNC_ACTIVE_LOW), retrace=0, interrupt=0.
- Reset mid-frame returns all outputs to these values on the next edge.
- Counters:
  - x increments every clk.
  - At x = H_TOTAL-1: x wraps to 0 and y increments.
  - At y = V_TOTAL-1 on that same wrap: y wraps to 0.
- Output registration: all outputs are registers; hsync, vsync, blank and retrace are computed from next-state counters, so they are aligned with the x/y values presented in the same cycle (zero relative latency).
- hsync: active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (default 1048..1183).
- vsync: active for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (default 771..776). Spans whole lines, changes at x=0.
- blank = (x >= active_width) | (y >= V_VISIBLE), where active_width = narrow_960 ? NARROW_VISIBLE : H_VISIBLE.
- narrow_960 is sampled every cycle; toggling it mid-line takes effect on the next clk. Line and frame totals are unchanged in narrow mode.
- retrace = 1 only when x = H_TOTAL-1. It pulses on every line, including vblank lines; the next cycle presents x=0.
- Interrupt set events:
  - hblank_evt: x transitions to active_width while y < V_VISIBLE, and enable_interrupt_on_hblank=1.
  - vblank_evt: x transitions 0 with y transitioning to V_VISIBLE, and enable_interrupt_on_vblank=1.
- Interrupt flag update:
  - Either event sets interrupt; it appears in the same cycle blank rises.
  - cli=1 with no set event clears interrupt on the next edge.
  - Set event and cli in the same cycle: set wins, interrupt stays 1 (no event lost).
  - Flag holds otherwise. Enables are level-checked only at the event cycle; dropping an enable does not clear a pending flag.
- Widths: x 11-bit, y 10-bit unsigned. Parameter sums must fit. No other saturation is required.

Optional Feature:
- Macro VGA_SCAN_TIMER_NARROW_EN.
- Defined: narrow_960 behaves as specified above.
- Undefined:
  - narrow_960 is ignored (listed as unused).
  - active_width is the constant H_VISIBLE.
  - The hblank event always fires at x = H_VISIBLE.
  - Saves the comparator and mux.

Test Plan:
- Reset: assert rst_n=0 at x=500, y=300 -> next cycle x=0, y=0, blank=0, hsync=vsync=1, interrupt=0.
- Line timing:
  - hsync=0 exactly at x=1048..1183.
  - blank=1 exactly at x=1024..1343.
  - retrace pulses once at x=1343, then x=0 with y+1.
- Frame timing:
  - y wraps 805 -> 0.
  - vsync=0 for y=771..776 over full lines.
  - blank=1 for all of y=768..805.
  - 806 retrace pulses per frame.
- Narrow mode with macro defined: narrow_960=1 -> blank rises at x=960, hsync unchanged at 1048. Without the macro, blank rises at 1024.
- Interrupts:
  - hblank enabled -> interrupt rises at (x=1024, y=0).
  - cli=1 for one cycle -> interrupt=0.
  - vblank enabled only -> rises once per frame at (0, 768).
- Set/clear collision: hold cli=1 continuously with hblank enabled -> interrupt=1 for exactly one cycle per visible line at x=1024.

Source files
------------

// File: rtl/vga_scan_timer.sv
// vga_scan_timer: XGA-style raster timing generator (x/y beam position, hsync/vsync/blank, retrace pulse, sticky blank interrupt).
// Ports: clk, rst_n (sync, active-low), cli (clear interrupt), enable_interrupt_on_hblank/vblank (interrupt source arms),
//   narrow_960 (blank x >= NARROW_VISIBLE); outputs x, y, hsync, vsync, retrace, blank, interrupt (all registered).
// Optional: define VGA_SCAN_TIMER_NARROW_EN to honour narrow_960; otherwise it is ignored and the active width is H_VISIBLE.
module vga_scan_timer #(
  parameter int H_VISIBLE      = 1024,
  parameter int H_FRONT        = 24,
  parameter int H_SYNC         = 136,
  parameter int H_BACK         = 160,
  parameter int V_VISIBLE      = 768,
  parameter int V_FRONT        = 3,
  parameter int V_SYNC         = 6,
  parameter int V_BACK         = 29,
  parameter int NARROW_VISIBLE = 960,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
  input  logic        enable_interrupt_on_hblank,
  input  logic        enable_interrupt_on_vblank,
  input  logic        narrow_960,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        interrupt
);
  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  logic [10:0] x_q, x_d, active_width;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic        retrace_q, retrace_d, irq_q, irq_d, line_end, set_evt;
`ifdef VGA_SCAN_TIMER_NARROW_EN
  assign active_width = narrow_960 ? 11'(NARROW_VISIBLE) : 11'(H_VISIBLE);
`else
  logic unused_narrow;
  assign unused_narrow = narrow_960;
  assign active_width = 11'(H_VISIBLE);
`endif
  // Strobes are derived from the next-state counters so they line up with the x/y registered alongside them.
  always_comb begin
    line_end  = x_q == H_LAST;
    x_d       = line_end ? '0 : x_q + 11'd1;
    y_d       = !line_end ? y_q : (y_q == V_LAST ? '0 : y_q + 10'd1);
    hsync_d   = (x_d >= HS_START && x_d < HS_END) ^ SYNC_ACTIVE_LOW;
    vsync_d   = (y_d >= VS_START && y_d < VS_END) ^ SYNC_ACTIVE_LOW;
    blank_d   = x_d >= active_width || y_d >= V_VIS;
    retrace_d = x_d == H_LAST;
    set_evt   = (enable_interrupt_on_hblank && x_d == active_width && y_d < V_VIS) ||
                (enable_interrupt_on_vblank && x_d == '0 && y_d == V_VIS);
    irq_d     = set_evt || (irq_q && !cli);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      hsync_q   <= SYNC_ACTIVE_LOW;
      vsync_q   <= SYNC_ACTIVE_LOW;
      blank_q   <= 1'b0;
      retrace_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_q   <= blank_d;
      retrace_q <= retrace_d;
      irq_q     <= irq_d;
    end
  end
  assign x         = x_q;
  assign y         = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign retrace   = retrace_q;
  assign interrupt = irq_q;
endmodule
